// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial link blocks (transmitter now, receiver later).
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } serial_state_e;

  localparam int SERIAL_DIV_MIN = 2;

  // $clog2 collapses to 0 for n<=1, which would give zero-width vectors
  function automatic int safe_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_bitclk.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the first/last cycle of each bit.
// sclk_level is a flop that follows (count >= DIV/2) whenever level_en is set, otherwise it is 0.
module serial_bitclk
  import serial_pkg::*;
#(
  parameter int DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic level_en,
  output logic bit_start,
  output logic bit_end,
  output logic sclk_level
);

  localparam int DIV_EFF = (DIV < SERIAL_DIV_MIN) ? SERIAL_DIV_MIN : DIV;
  localparam int CNT_W = safe_width(DIV_EFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV_EFF / 2);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = (count == CNT_LAST) ? '0 : count + 1'b1;
    end
  end

  // sclk is computed from the next count so the flop output lines up with the count it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      sclk_level <= 1'b0;
    end else begin
      count      <= count_nxt;
      sclk_level <= level_en & (count_nxt >= CNT_HALF);
    end
  end

  assign bit_start = (count == '0);
  assign bit_end   = en & (count == CNT_LAST);

endmodule

// File: rtl/serial_tx_stream.sv
// Valid/ready fed synchronous serial transmitter with parametrised width, rate, bit order and gap.
// Optional even parity bit after the data bits when SERIAL_TX_PARITY_EN is defined.
module serial_tx_stream
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV       = 1024,
  parameter int MSB_FIRST = 0,
  parameter int GAP       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sclk,
  output logic              sdata,
  output logic              busy
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int BIT_W = $clog2(NBITS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam int GAP_W = safe_width(GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP);

  serial_state_e     state;
  serial_state_e     state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              handshake;
  logic              bit_start;
  logic              bit_end;
  logic              sclk_level;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign handshake = in_valid & in_ready;
  assign sclk      = sclk_level;

  serial_bitclk #(.DIV(DIV)) u_bitclk (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state != ST_IDLE),
    .clr        (handshake),
    .level_en   (state == ST_SHIFT),
    .bit_start  (bit_start),
    .bit_end    (bit_end),
    .sclk_level (sclk_level)
  );

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  always_comb begin
    shreg_nxt = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (handshake) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_end && bit_cnt == BIT_LAST) state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (bit_end && gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // First bit is driven at the handshake edge; later bits change on the last cycle of the previous one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sdata   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            shreg   <= in_data;
            bit_cnt <= '0;
            sdata   <= first_bit(in_data);
`ifdef SERIAL_TX_PARITY_EN
            parity  <= ^in_data;
`endif
          end
        end
        ST_SHIFT: begin
          gap_cnt <= '0;
          if (bit_end && bit_cnt != BIT_LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= shreg_nxt;
`ifdef SERIAL_TX_PARITY_EN
            if (bit_cnt == BIT_W'(DATA_W - 1)) sdata <= parity;
            else sdata <= first_bit(shreg_nxt);
`else
            sdata   <= first_bit(shreg_nxt);
`endif
          end
        end
        ST_GAP: begin
          if (bit_start) gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_stream.sv
// Scoreboard bench for serial_tx_stream: instance 0 is LSB-first with no gap, instance 1 is
// MSB-first with a 2-period gap. Frames are decoded from sclk rising edges and compared to queued words.
module tb_serial_tx_stream;

  localparam int DATA_W = 8;
  localparam int DIV    = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  typedef struct {
    logic [DATA_W-1:0] word;
    int                hs;
    bit                b2b;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data [2];
  logic              in_valid [2];
  logic              in_ready [2];
  logic              sclk [2];
  logic              sdata [2];
  logic              busy [2];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the on-wire bit sequence, bit k being the k-th period of the frame
  function automatic logic [NBITS-1:0] frame_bits(input logic [DATA_W-1:0] w, input int msbf);
    logic [NBITS-1:0] f;
    f = '0;
    for (int k = 0; k < DATA_W; k++) f[k] = (msbf != 0) ? w[DATA_W-1-k] : w[k];
    if (NBITS > DATA_W) f[NBITS-1] = ^w;
    return f;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int MSBF = g;
    localparam int GAPV = (g == 1) ? 2 : 0;

    serial_tx_stream #(
      .DATA_W(DATA_W), .DIV(DIV), .MSB_FIRST(MSBF), .GAP(GAPV)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .sclk     (sclk[g]),
      .sdata    (sdata[g]),
      .busy     (busy[g])
    );

    bit               active = 1'b0;
    logic             prev_sclk = 1'b0;
    logic             hold_bit = 1'b0;
    exp_t             cur;
    int               start = 0;
    int               last_start = -1000;
    int               nrise = 0;
    logic [NBITS-1:0] got = '0;
    logic [NBITS-1:0] fb;

    always @(negedge clk) begin
      if (!rst_n) begin
        active    = 1'b0;
        prev_sclk = 1'b0;
      end else begin
        if (active && busy[g] !== 1'b1) begin
          checkOutput($sformatf("i%0d busy cycles", g), cyc - start, (NBITS + GAPV) * DIV);
          checkOutput($sformatf("i%0d sclk rises", g), nrise, NBITS);
          checkOutput($sformatf("i%0d frame bits", g), got, frame_bits(cur.word, MSBF));
          active = 1'b0;
        end else if (!active && busy[g] === 1'b1) begin
          if (exp_q[g].size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL i%0d unexpected frame: busy rose with no word queued", g);
            active = 1'b1;
            cur.word = '0;
            start = cyc;
            nrise = 0;
            got = '0;
          end else begin
            cur    = exp_q[g].pop_front();
            active = 1'b1;
            start  = cyc;
            nrise  = 0;
            got    = '0;
            fb     = frame_bits(cur.word, MSBF);
            checkOutput($sformatf("i%0d first-bit latency", g), cyc, cur.hs);
            checkOutput($sformatf("i%0d first bit", g), sdata[g], fb[0]);
            if (cur.b2b)
              checkOutput($sformatf("i%0d back-to-back spacing", g), start - last_start,
                          (NBITS + GAPV) * DIV + 1);
            last_start = start;
          end
        end

        if (active) begin
          if (sclk[g] && !prev_sclk) begin
            checkOutput($sformatf("i%0d sclk rise offset", g), cyc - start, nrise * DIV + DIV / 2);
            if (nrise < NBITS) got[nrise] = sdata[g];
            hold_bit = sdata[g];
            nrise++;
          end else if (sclk[g] && prev_sclk) begin
            checkOutput($sformatf("i%0d sdata stable", g), sdata[g], hold_bit);
          end
        end else begin
          checkOutput($sformatf("i%0d idle sclk", g), sclk[g], 0);
        end
        prev_sclk = sclk[g];
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [DATA_W-1:0] word, input bit hold,
                               input bit b2b);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    in_data[idx]  = word;
    in_valid[idx] = 1'b1;
    while (in_ready[idx] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready[idx] !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL i%0d handshake timeout: in_ready=%b after %0d cycles, expected 1",
               idx, in_ready[idx], waited);
      in_valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.word = word;
    e.hs   = cyc;
    e.b2b  = b2b;
    exp_q[idx].push_back(e);
    if (!hold) begin
      in_valid[idx] = 1'b0;
      in_data[idx]  = DATA_W'($urandom);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < budget && (busy[0] === 1'b1 || busy[1] === 1'b1 ||
                              exp_q[0].size() != 0 || exp_q[1].size() != 0));
    if (n >= budget) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle timeout: busy=%b/%b pending=%0d/%0d after %0d cycles, expected idle",
               busy[0], busy[1], exp_q[0].size(), exp_q[1].size(), n);
    end
  endtask

  task automatic checkResetValues(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s i%0d sclk", tag, i), sclk[i], 0);
      checkOutput($sformatf("%s i%0d sdata", tag, i), sdata[i], 0);
      checkOutput($sformatf("%s i%0d busy", tag, i), busy[i], 0);
      checkOutput($sformatf("%s i%0d in_ready", tag, i), in_ready[i], 1);
    end
  endtask

  task automatic randomLoop(input int idx);
    bit prev_hold = 1'b0;
    bit hold;
    for (int n = 0; n < 20; n++) begin
      hold = ($urandom_range(0, 2) == 0) && (n != 19);
      if (!prev_hold) repeat ($urandom_range(0, 5)) @(negedge clk);
      applyStimulus(idx, DATA_W'($urandom), hold, prev_hold);
      prev_hold = hold;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkResetValues("power-up");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fork
      applyStimulus(0, 8'h0F, 1'b0, 1'b0);
      applyStimulus(1, 8'h0F, 1'b0, 1'b0);
    join
    waitIdle(200);

    repeat (3) @(negedge clk);
    checkOutput("i0 idle sdata hold", sdata[0], 0);
    checkOutput("i1 idle sdata hold", sdata[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("idle reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fork
      begin
        applyStimulus(0, 8'h55, 1'b1, 1'b0);
        applyStimulus(0, 8'hAA, 1'b0, 1'b1);
      end
      begin
        applyStimulus(1, 8'h55, 1'b1, 1'b0);
        applyStimulus(1, 8'hAA, 1'b0, 1'b1);
      end
    join
    waitIdle(300);

    fork
      applyStimulus(0, 8'hFF, 1'b0, 1'b0);
      applyStimulus(1, 8'hFF, 1'b0, 1'b0);
    join
    repeat (14) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("i%0d bit3 sclk", i), sclk[i], 1);
      checkOutput($sformatf("i%0d bit3 sdata", i), sdata[i], 1);
    end
    rst_n = 1'b0;
    #1;
    checkResetValues("frame reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      applyStimulus(0, 8'h01, 1'b0, 1'b0);
      applyStimulus(1, 8'h01, 1'b0, 1'b0);
    join
    waitIdle(200);

    fork
      randomLoop(0);
      randomLoop(1);
    join
    waitIdle(3000);
    checkOutput("i0 pending words", exp_q[0].size(), 0);
    checkOutput("i1 pending words", exp_q[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
